// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states,
// and the mux-select / alu_op codes also understood by alu_control.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_t;

    // alu_op values are decoded by alu_control; keep the two in step.
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG    = 2'b00,
        SRCB_FOUR   = 2'b01,
        SRCB_IMM    = 2'b10,
        SRCB_IMM_SH = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_R)  || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Main controller FSM for the multicycle MIPS datapath: state register plus
// a Moore-style output decode (FETCH strobes and MEM_WRITE retire follow mem_ready).
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       retired,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q;
    state_t state_d;

    logic raw_pc_write;
    logic raw_pc_write_cond;
    logic raw_mem_read;
    logic raw_mem_write;
    logic raw_ir_write;
    logic raw_reg_write;
    logic raw_retired;
    logic raw_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            default:     state_d = S_FETCH;
        endcase
    end

    always_comb begin
        raw_pc_write      = 1'b0;
        raw_pc_write_cond = 1'b0;
        raw_mem_read      = 1'b0;
        raw_mem_write     = 1'b0;
        raw_ir_write      = 1'b0;
        raw_reg_write     = 1'b0;
        raw_retired       = 1'b0;
        raw_illegal       = 1'b0;
        iord              = 1'b0;
        mem_to_reg        = 1'b0;
        reg_dst           = 1'b0;
        alu_src_a         = 1'b0;
        alu_src_b         = SRCB_REG;
        alu_op            = ALU_ADD;
        pc_src            = PCSRC_ALU;
        case (state_q)
            S_FETCH: begin
                raw_mem_read = 1'b1;
                raw_ir_write = mem_ready;
                raw_pc_write = mem_ready;
                alu_src_b    = SRCB_FOUR;
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode is decoded.
                alu_src_b   = SRCB_IMM_SH;
                raw_illegal = !is_legal_op(opcode);
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                raw_mem_read = 1'b1;
                iord         = 1'b1;
            end
            S_MEM_WB: begin
                raw_reg_write = 1'b1;
                mem_to_reg    = 1'b1;
                raw_retired   = 1'b1;
            end
            S_MEM_WRITE: begin
                raw_mem_write = 1'b1;
                iord          = 1'b1;
                raw_retired   = mem_ready;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                raw_reg_write = 1'b1;
                reg_dst       = 1'b1;
                raw_retired   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a         = 1'b1;
                alu_op            = ALU_SUB;
                raw_pc_write_cond = 1'b1;
                pc_src            = PCSRC_ALUOUT;
                raw_retired       = 1'b1;
            end
            S_JUMP: begin
                raw_pc_write = 1'b1;
                pc_src       = PCSRC_JUMP;
                raw_retired  = 1'b1;
            end
            S_ADDI_WB: begin
                raw_reg_write = 1'b1;
                raw_retired   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Architectural side effects are suppressed for as long as reset is held.
    assign pc_write      = rst_n & raw_pc_write;
    assign pc_write_cond = rst_n & raw_pc_write_cond;
    assign pc_en         = pc_write | (pc_write_cond & zero);
    assign mem_read      = rst_n & raw_mem_read;
    assign mem_write     = rst_n & raw_mem_write;
    assign ir_write      = rst_n & raw_ir_write;
    assign reg_write     = rst_n & raw_reg_write;
    assign retired       = rst_n & raw_retired;
    assign illegal       = rst_n & raw_illegal;
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed table-driven check of multicycle_control plus hand-written reset sequences.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, retired, illegal;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_en(pc_en), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .retired(retired), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    // {pcw pcwc pcen}_{iord mrd mwr}_{irw}_{m2r rdst rw}_{asa}_{asb}_{aop}_{psrc}_{ret ill}
    logic [18:0] act_ctl;
    assign act_ctl = {pc_write, pc_write_cond, pc_en, iord, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                      retired, illegal};

    localparam logic [18:0] C_RST = 19'b000_000_0_000_0_01_00_00_00;
    localparam logic [18:0] C_F1  = 19'b101_010_1_000_0_01_00_00_00;
    localparam logic [18:0] C_F0  = 19'b000_010_0_000_0_01_00_00_00;
    localparam logic [18:0] C_DEC = 19'b000_000_0_000_0_11_00_00_00;
    localparam logic [18:0] C_ILL = 19'b000_000_0_000_0_11_00_00_01;
    localparam logic [18:0] C_MA  = 19'b000_000_0_000_1_10_00_00_00;
    localparam logic [18:0] C_MR  = 19'b000_110_0_000_0_00_00_00_00;
    localparam logic [18:0] C_MWB = 19'b000_000_0_101_0_00_00_00_10;
    localparam logic [18:0] C_MW0 = 19'b000_101_0_000_0_00_00_00_00;
    localparam logic [18:0] C_MW1 = 19'b000_101_0_000_0_00_00_00_10;
    localparam logic [18:0] C_EX  = 19'b000_000_0_000_1_00_10_00_00;
    localparam logic [18:0] C_RWB = 19'b000_000_0_011_0_00_00_00_10;
    localparam logic [18:0] C_BR1 = 19'b011_000_0_000_1_00_01_01_10;
    localparam logic [18:0] C_BR0 = 19'b010_000_0_000_1_00_01_01_10;
    localparam logic [18:0] C_J   = 19'b101_000_0_000_0_00_00_10_10;
    localparam logic [18:0] C_AEX = 19'b000_000_0_000_1_10_00_00_00;
    localparam logic [18:0] C_AWB = 19'b000_000_0_001_0_00_00_00_10;
    localparam logic [5:0]  OP_BAD = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [18:0] ctl;
    } vec_t;

    vec_t vq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input logic [18:0] c);
        vec_t v;
        v.rst = r; v.op = op; v.z = z; v.mr = mr; v.st = st; v.ctl = c;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;

        // R-type
        add(1, OP_R,    0, 1, S_FETCH,     C_F1);
        add(1, OP_R,    0, 1, S_DECODE,    C_DEC);
        add(1, OP_R,    0, 0, S_EXECUTE,   C_EX);
        add(1, OP_R,    0, 1, S_R_WB,      C_RWB);
        // LW with three stall cycles in MEM_READ
        add(1, OP_LW,   0, 1, S_FETCH,     C_F1);
        add(1, OP_LW,   0, 1, S_DECODE,    C_DEC);
        add(1, OP_LW,   0, 1, S_MEM_ADDR,  C_MA);
        add(1, OP_LW,   0, 0, S_MEM_READ,  C_MR);
        add(1, OP_LW,   0, 0, S_MEM_READ,  C_MR);
        add(1, OP_LW,   0, 0, S_MEM_READ,  C_MR);
        add(1, OP_LW,   0, 1, S_MEM_READ,  C_MR);
        add(1, OP_LW,   0, 1, S_MEM_WB,    C_MWB);
        // SW, no stall
        add(1, OP_SW,   0, 1, S_FETCH,     C_F1);
        add(1, OP_SW,   0, 1, S_DECODE,    C_DEC);
        add(1, OP_SW,   0, 0, S_MEM_ADDR,  C_MA);
        add(1, OP_SW,   0, 1, S_MEM_WRITE, C_MW1);
        // BEQ taken then not taken
        add(1, OP_BEQ,  1, 1, S_FETCH,     C_F1);
        add(1, OP_BEQ,  1, 0, S_DECODE,    C_DEC);
        add(1, OP_BEQ,  1, 1, S_BRANCH,    C_BR1);
        add(1, OP_BEQ,  0, 1, S_FETCH,     C_F1);
        add(1, OP_BEQ,  0, 1, S_DECODE,    C_DEC);
        add(1, OP_BEQ,  0, 1, S_BRANCH,    C_BR0);
        // J
        add(1, OP_J,    0, 1, S_FETCH,     C_F1);
        add(1, OP_J,    0, 1, S_DECODE,    C_DEC);
        add(1, OP_J,    0, 1, S_JUMP,      C_J);
        // ADDI
        add(1, OP_ADDI, 0, 1, S_FETCH,     C_F1);
        add(1, OP_ADDI, 0, 1, S_DECODE,    C_DEC);
        add(1, OP_ADDI, 0, 0, S_ADDI_EX,   C_AEX);
        add(1, OP_ADDI, 0, 1, S_ADDI_WB,   C_AWB);
        // illegal opcode, then a fetch that waits two cycles for memory
        add(1, OP_BAD,  0, 1, S_FETCH,     C_F1);
        add(1, OP_BAD,  0, 1, S_DECODE,    C_ILL);
        add(1, OP_J,    0, 0, S_FETCH,     C_F0);
        add(1, OP_J,    0, 0, S_FETCH,     C_F0);
        add(1, OP_J,    0, 1, S_FETCH,     C_F1);
        add(1, OP_J,    0, 1, S_DECODE,    C_DEC);
        add(1, OP_J,    0, 1, S_JUMP,      C_J);
        // SW with one stall cycle
        add(1, OP_SW,   0, 1, S_FETCH,     C_F1);
        add(1, OP_SW,   0, 1, S_DECODE,    C_DEC);
        add(1, OP_SW,   0, 1, S_MEM_ADDR,  C_MA);
        add(1, OP_SW,   0, 0, S_MEM_WRITE, C_MW0);
        add(1, OP_SW,   0, 1, S_MEM_WRITE, C_MW1);
        // reset while LW stalls in MEM_READ aborts it without a retire
        add(1, OP_LW,   0, 1, S_FETCH,     C_F1);
        add(1, OP_LW,   0, 1, S_DECODE,    C_DEC);
        add(1, OP_LW,   0, 1, S_MEM_ADDR,  C_MA);
        add(1, OP_LW,   0, 0, S_MEM_READ,  C_MR);
        add(0, OP_LW,   0, 0, S_FETCH,     C_RST);
        add(1, OP_R,    0, 1, S_FETCH,     C_F1);
        add(1, OP_R,    0, 1, S_DECODE,    C_DEC);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'(state), 32'(S_FETCH));
        check("reset_ctl", 32'(act_ctl), 32'(C_RST));

        foreach (vq[i]) begin
            @(posedge clk);
            #1;
            rst_n = vq[i].rst; opcode = vq[i].op; zero = vq[i].z; mem_ready = vq[i].mr;
            @(negedge clk);
            check($sformatf("row%0d_state", i), 32'(state), 32'(vq[i].st));
            check($sformatf("row%0d_ctl", i), 32'(act_ctl), 32'(vq[i].ctl));
        end

        // reset asserted in the middle of an EXECUTE cycle
        @(posedge clk);
        #1;
        check("mid_exec_state", 32'(state), 32'(S_EXECUTE));
        #2 rst_n = 1'b0;
        #1;
        check("mid_exec_rst_state", 32'(state), 32'(S_FETCH));
        check("mid_exec_rst_ctl", 32'(act_ctl), 32'(C_RST));
        @(negedge clk);
        check("rst_held_ctl", 32'(act_ctl), 32'(C_RST));
        check("rst_held_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        check("release_state", 32'(state), 32'(S_FETCH));
        check("release_mem_read", 32'(mem_read), 32'd1);
        check("release_ctl", 32'(act_ctl), 32'(C_F0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
